// File: rtl/iiitb_serial_pkg.sv
// Shared definitions for the serial link (transmit and receive sides).
//   SERIAL_WIDTH     default parallel word width
//   LSB_FIRST_ORDER  first serial bit maps to word bit 0
//   MSB_FIRST_ORDER  first serial bit maps to word bit WIDTH-1
package iiitb_serial_pkg;

  localparam int unsigned SERIAL_WIDTH    = 8;
  localparam int unsigned LSB_FIRST_ORDER = 1;
  localparam int unsigned MSB_FIRST_ORDER = 0;

endpackage

// File: rtl/iiitb_sipo_shift.sv
// Serial bit accumulator for the SIPO receiver.
//   clk, rst    clock and synchronous active-high reset
//   start       frame alignment; discards any partial word
//   bit_valid   serial_in carries a bit this cycle
//   serial_in   serial data bit
//   word        assembled word including the current bit (valid with word_done)
//   word_done   current bit completes a word (combinational strobe)
//   busy        partial word in progress (bit count != 0)
module iiitb_sipo_shift
  import iiitb_serial_pkg::*;
#(
  parameter int unsigned WIDTH     = SERIAL_WIDTH,
  parameter int unsigned LSB_FIRST = LSB_FIRST_ORDER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             serial_in,
  output logic [WIDTH-1:0] word,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_next;
  logic [CNT_W-1:0] cnt;

  generate
    if (LSB_FIRST == LSB_FIRST_ORDER) begin : g_lsb
      assign sh_next = {serial_in, sh[WIDTH-1:1]};
    end else begin : g_msb
      assign sh_next = {sh[WIDTH-2:0], serial_in};
    end
  endgenerate

  // Stale bits left in sh after a start are harmless: a full frame of
  // WIDTH bits shifts every one of them out before the word completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (bit_valid) begin
      sh <= sh_next;
      if (start)
        cnt <= CNT_W'(1);
      else if (cnt == LAST)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
    end else if (start) begin
      cnt <= '0;
    end
  end

  assign word      = sh_next;
  assign word_done = bit_valid & ~start & (cnt == LAST);
  assign busy      = (cnt != '0);

endmodule

// File: rtl/iiitb_sipo.sv
// Serial-in parallel-out receiver with one-entry output holding register.
//   clk, rst    clock and synchronous active-high reset
//   start       frame alignment; aborts any partial word
//   bit_valid   serial_in carries a bit this cycle
//   serial_in   serial data bit
//   data_out    completed word from the holding register
//   data_valid  holding register full
//   data_ready  consumer accepts data_out
//   overrun     one-cycle pulse when a completed word is dropped
//   busy        partial word in progress
module iiitb_sipo
  import iiitb_serial_pkg::*;
#(
  parameter int unsigned WIDTH     = SERIAL_WIDTH,
  parameter int unsigned LSB_FIRST = LSB_FIRST_ORDER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  output logic             busy
);

  logic [WIDTH-1:0] word;
  logic             word_done;
  logic [WIDTH-1:0] hold;
  logic             hold_valid;
  logic             ovr;

  iiitb_sipo_shift #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .serial_in (serial_in),
    .word      (word),
    .word_done (word_done),
    .busy      (busy)
  );

  // A completing word may replace the held one only if the held one is
  // being drained on the same edge; otherwise the new word is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      ovr <= 1'b0;
      if (word_done) begin
        if (!hold_valid || data_ready) begin
          hold       <= word;
          hold_valid <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end else if (hold_valid && data_ready) begin
        hold_valid <= 1'b0;
      end
    end
  end

  assign data_out   = hold;
  assign data_valid = hold_valid;
  assign overrun    = ovr;

endmodule
